serial_csla_adder: RTL and testbench



---
 rtl/serial_add_pkg.sv | 18 +
 rtl/serial_csla_adder_csla4.sv | 22 ++
 rtl/serial_csla_adder.sv | 149 ++++++++++++++
 tb/tb_serial_csla_adder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, slice width,
// and the nibble-counter width helper.
package serial_add_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Never returns 0 so a counter declared with it always has at least one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_csla_adder_csla4.sv
// 4-bit carry-select adder slice: the low pair ripples, the high pair is
// precomputed for both carries and selected by the low-pair carry-out.
module CSLA4Bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic       Cout,
  output logic [3:0] S
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  assign lo  = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, Cin};
  assign hi0 = {1'b0, A[3:2]} + {1'b0, B[3:2]};
  assign hi1 = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;

  assign S[1:0]          = lo[1:0];
  assign {Cout, S[3:2]}  = lo[2] ? hi1 : hi0;

endmodule

// File: rtl/serial_csla_adder.sv
// Digit-serial WIDTH-bit adder running one nibble per cycle through CSLA4Bit.
// Optional signed-overflow output is enabled with the SERIAL_ADD_OVF_EN macro.
module serial_csla_adder
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int N     = WIDTH / NIBBLE;
  localparam int CNT_W = cnt_width(N);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIBBLE-1:0]  nib_a;
  logic [NIBBLE-1:0]  nib_b;
  logic [NIBBLE-1:0]  slice_s;
  logic               slice_cout;
  logic               last_nib;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        nib_a = a_q[k*NIBBLE +: NIBBLE];
        nib_b = b_q[k*NIBBLE +: NIBBLE];
      end
    end
  end

  CSLA4Bit u_slice (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .Cout (slice_cout),
    .S    (slice_s)
  );

  assign last_nib = (cnt_q == CNT_W'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            sum_d[k*NIBBLE +: NIBBLE] = slice_s;
          end
        end
        carry_d = slice_cout;
        // Counter parks at N-1 on the final nibble so it never wraps.
        if (last_nib) begin
          state_d = ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_s[NIBBLE-1] != a_q[WIDTH-1]);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_csla_adder.sv
// Directed scoreboard bench for serial_csla_adder (WIDTH = 16); the overflow
// scenarios are included when SERIAL_ADD_OVF_EN is defined.
module tb_serial_csla_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
  logic             ovf_exp_q[$];
`endif

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH:0]   exp_q[$];

  always #5 clk = ~clk;

  serial_csla_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  task automatic check_output(input string tag, input logic [WIDTH:0] observed,
                              input logic [WIDTH:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic push_expected(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv);
    logic [WIDTH:0] full;
    full = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
    exp_q.push_back(full);
`ifdef SERIAL_ADD_OVF_EN
    ovf_exp_q.push_back((av[WIDTH-1] == bv[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]));
`endif
  endtask

  // Drives one operand set; returns at the falling edge after the accept edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic cv, input bit hold_valid);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    push_expected(av, bv, cv);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_output("out_valid_timeout", {{WIDTH{1'b0}}, out_valid}, 1);
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check_output(tag, {cout, sum}, e);
`ifdef SERIAL_ADD_OVF_EN
    begin
      logic eo;
      eo = (ovf_exp_q.size() != 0) ? ovf_exp_q.pop_front() : 1'bx;
      check_output({tag, "_ovf"}, {{WIDTH{1'b0}}, ovf}, {{WIDTH{1'b0}}, eo});
    end
`endif
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("release_in_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    check_output("release_out_valid", {{WIDTH{1'b0}}, out_valid}, 0);
  endtask

  initial begin
    int lat;
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    check_output("rst_out_valid", {{WIDTH{1'b0}}, out_valid}, 0);
    check_output("rst_busy", {{WIDTH{1'b0}}, busy}, 0);
    check_output("rst_sum_cout", {cout, sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with latency measured from the accept edge
    apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    check_output("basic_busy", {{WIDTH{1'b0}}, busy}, 1);
    wait_result(lat);
    check_output("basic_latency", lat[WIDTH:0], 4);
    check_output("basic_const", {cout, sum}, 17'h05555);
    check_result("basic");
    handshake();

    // Carry ripples across every nibble boundary
    apply_stimulus(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait_result(lat);
    check_output("carry_const", {cout, sum}, 17'h10000);
    check_result("carry_chain");
    handshake();

    // Backpressure: result held, in_valid ignored while DONE
    apply_stimulus(16'h8001, 16'h8001, 1'b0, 1'b0);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_out_valid", {{WIDTH{1'b0}}, out_valid}, 1);
      check_output("bp_hold", {cout, sum}, 17'h10002);
      check_output("bp_in_ready", {{WIDTH{1'b0}}, in_ready}, 0);
      if (i == 2) begin
        a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_result("bp");
    handshake();
    repeat (6) @(negedge clk);
    check_output("bp_ignored_valid", {{WIDTH{1'b0}}, out_valid}, 0);
    check_output("bp_ignored_busy", {{WIDTH{1'b0}}, busy}, 0);

    // Reset after two nibbles discards the partial result
    apply_stimulus(16'h00FF, 16'h0F0F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrst_sum_cout", {cout, sum}, 0);
    check_output("midrst_out_valid", {{WIDTH{1'b0}}, out_valid}, 0);
    check_output("midrst_busy", {{WIDTH{1'b0}}, busy}, 0);
    check_output("midrst_in_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    void'(exp_q.pop_front());
`ifdef SERIAL_ADD_OVF_EN
    check_output("midrst_ovf", {{WIDTH{1'b0}}, ovf}, 0);
    void'(ovf_exp_q.pop_front());
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_result(lat);
    check_output("post_rst_const", {cout, sum}, 17'h00002);
    check_result("post_rst");
    handshake();

    // Back-to-back: second operand set waits with in_valid held high
    apply_stimulus(16'hABCD, 16'h1111, 1'b0, 1'b1);
    a   = 16'h0F0F;
    b   = 16'hF0F1;
    cin = 1'b1;
    push_expected(16'h0F0F, 16'hF0F1, 1'b1);
    wait_result(lat);
    check_result("b2b_first");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("b2b_idle_ready", {{WIDTH{1'b0}}, in_ready}, 1);
    @(negedge clk);
    check_output("b2b_accepted", {{WIDTH{1'b0}}, busy}, 1);
    in_valid = 1'b0;
    wait_result(lat);
    check_output("b2b_latency", lat[WIDTH:0], 4);
    check_output("b2b_const", {cout, sum}, 17'h10001);
    check_result("b2b_second");
    handshake();

`ifdef SERIAL_ADD_OVF_EN
    apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_result(lat);
    check_output("ovf_pos", {{WIDTH{1'b0}}, ovf}, 1);
    check_output("ovf_pos_sum", {cout, sum}, 17'h08000);
    check_result("ovf_pos_sb");
    handshake();
    apply_stimulus(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_result(lat);
    check_output("ovf_neg", {{WIDTH{1'b0}}, ovf}, 1);
    check_output("ovf_neg_sum", {cout, sum}, 17'h10000);
    check_result("ovf_neg_sb");
    handshake();
    apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    check_output("ovf_clear_on_accept", {{WIDTH{1'b0}}, ovf}, 0);
    wait_result(lat);
    check_output("ovf_none", {{WIDTH{1'b0}}, ovf}, 0);
    check_result("ovf_none_sb");
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
